// File: rtl/trunc_unit_scheduler.sv
// rtl/trunc_unit_scheduler.sv - round-robin scheduler sharing one truncation unit between two requesters
module trunc_unit_scheduler #(
    parameter int SETTLE = 2,
    parameter int CNT_W  = 16
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Req0,
    input  logic [31:0]      Req0In1,
    input  logic [31:0]      Req0In2,
    output logic             Gnt0,
    input  logic             Req1,
    input  logic [31:0]      Req1In1,
    input  logic [31:0]      Req1In2,
    output logic             Gnt1,
    output logic [31:0]      TruncIn1,
    output logic [31:0]      TruncIn2,
    output logic             TruncEnable,
    input  logic [31:0]      TruncOut,
    output logic             RspValid,
    output logic             RspId,
    output logic [31:0]      RspData,
    input  logic             RspReady,
    output logic             Busy,
    output logic [CNT_W-1:0] OpCount
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [3:0]       cnt, cnt_nxt;
    logic             last_gnt, last_gnt_nxt;
    logic             winner;
    logic             gnt0_nxt, gnt1_nxt, en_nxt, valid_nxt, id_nxt;
    logic [31:0]      in1_nxt, in2_nxt, data_nxt;
    logic [CNT_W-1:0] count_nxt;

    // On a tie the requester that did not win last time goes next.
    assign winner = (Req0 && Req1) ? ~last_gnt : Req1;
    assign Busy   = (state != IDLE);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            last_gnt    <= 1'b1;
            Gnt0        <= 1'b0;
            Gnt1        <= 1'b0;
            TruncIn1    <= '0;
            TruncIn2    <= '0;
            TruncEnable <= 1'b0;
            RspValid    <= 1'b0;
            RspId       <= 1'b0;
            RspData     <= '0;
            OpCount     <= '0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            last_gnt    <= last_gnt_nxt;
            Gnt0        <= gnt0_nxt;
            Gnt1        <= gnt1_nxt;
            TruncIn1    <= in1_nxt;
            TruncIn2    <= in2_nxt;
            TruncEnable <= en_nxt;
            RspValid    <= valid_nxt;
            RspId       <= id_nxt;
            RspData     <= data_nxt;
            OpCount     <= count_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        last_gnt_nxt = last_gnt;
        gnt0_nxt     = 1'b0;
        gnt1_nxt     = 1'b0;
        in1_nxt      = TruncIn1;
        in2_nxt      = TruncIn2;
        en_nxt       = TruncEnable;
        valid_nxt    = RspValid;
        id_nxt       = RspId;
        data_nxt     = RspData;
        count_nxt    = OpCount;
        case (state)
            IDLE: begin
                en_nxt  = 1'b0;
                in1_nxt = '0;
                in2_nxt = '0;
                if (Req0 || Req1) begin
                    state_nxt    = RUN;
                    in1_nxt      = winner ? Req1In1 : Req0In1;
                    in2_nxt      = winner ? Req1In2 : Req0In2;
                    en_nxt       = 1'b1;
                    id_nxt       = winner;
                    last_gnt_nxt = winner;
                    cnt_nxt      = 4'(SETTLE);
                    gnt0_nxt     = ~winner;
                    gnt1_nxt     = winner;
                end
            end
            RUN: begin
                cnt_nxt = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    data_nxt  = TruncOut;
                    valid_nxt = 1'b1;
                    en_nxt    = 1'b0;
                    in1_nxt   = '0;
                    in2_nxt   = '0;
                    count_nxt = OpCount + CNT_W'(1);
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (RspReady) begin
                    valid_nxt = 1'b0;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
                en_nxt    = 1'b0;
                in1_nxt   = '0;
                in2_nxt   = '0;
                valid_nxt = 1'b0;
            end
        endcase
    end

endmodule

// File: doc/trunc_unit_scheduler.md
Name: trunc_unit_scheduler

Overview:
Shares one combinational truncation datapath unit between two requesters. The unit has two 32-bit operands, an Enable, and a 32-bit FinalOut result.
- Arbitrates round-robin and latches the winning operands.
- Drives the unit for a programmable settle time, then captures the result.
- Returns the result to the winner over a valid/ready handshake, tagged with the requester ID.
- Sits between requester FSMs (ALU/control path) and the truncation unit.

Parameters:
- SETTLE, 2: cycles the unit is driven with Enable=1 before FinalOut is captured (legal range 1..15).
- CNT_W, 16: width of the completed-operation counter.

Ports:
- Clk  in  1  system clock, rising edge.
- Rst_n  in  1  asynchronous active-low reset.
- Req0  in  1  requester 0 request, held until Gnt0.
- Req0In1  in  32  requester 0 operand 1.
- Req0In2  in  32  requester 0 operand 2.
- Gnt0  out  1  one-cycle pulse: requester 0 operands accepted.
- Req1, Req1In1, Req1In2, Gnt1: same as the requester 0 ports, for requester 1.
- TruncIn1  out  32  to unit In1.
- TruncIn2  out  32  to unit In2.
- TruncEnable  out  1  to unit Enable.
- TruncOut  in  32  from unit FinalOut.
- RspValid  out  1  result available.
- RspId  out  1  requester that owns RspData.
- RspData  out  32  captured result.
- RspReady  in  1  consumer accepts result.
- Busy  out  1  high in any state other than IDLE.
- OpCount  out  CNT_W  completed operations, wraps.

Behaviour:
Reset (async, Rst_n=0):
- State=IDLE; all outputs 0: Gnt*, TruncIn*, TruncEnable, RspValid, RspId, RspData, Busy, OpCount.
- LastGnt=1, so requester 0 wins the first tie.
- Takes effect immediately mid-operation: an in-flight operation is discarded and no Gnt or RspValid is produced for it.

IDLE:
- TruncEnable=0; TruncIn1/TruncIn2 driven 0.
- On a rising edge with Req0|Req1:
  - Pick the winner: the only requester if just one is asserted; otherwise the requester != LastGnt.
  - Latch the winner's operands into TruncIn1/TruncIn2.
  - Set RspId=winner and LastGnt=winner.
  - Load Cnt=SETTLE and go to RUN.
  - Register the GntX pulse so it is high for exactly the first RUN cycle.

RUN:
- TruncEnable=1; operands stable.
- Each edge decrements Cnt.
- At the edge where Cnt==1:
  - RspData<=TruncOut; RspValid<=1; TruncEnable<=0; TruncIn* <= 0.
  - OpCount<=OpCount+1 (wraps 2^CNT_W-1 -> 0).
  - Go to RESP.
- RUN therefore lasts exactly SETTLE cycles.
- Req inputs are ignored in RUN and RESP; the losing requester keeps Req high and is served next.

RESP:
- RspValid=1; RspData/RspId held stable until accepted.
- On an edge with RspReady=1: RspValid<=0, go to IDLE.
- RspReady high earlier than RESP has no effect.
- A new request is sampled no earlier than the first IDLE edge, so there is one idle cycle between operations.

Latency and requester protocol:
- Req sampled at edge E0 -> Gnt high in cycle E0..E0+1 -> RspValid rises at edge E0+SETTLE.
- A requester must deassert Req at the edge after seeing Gnt. A Req still high in IDLE is a new request.

Busy: Busy=(state!=IDLE).

Illegal encodings: any unused state encoding recovers to IDLE with outputs cleared.

Test Plan:
- Bench stub: TruncOut = TruncEnable ? TruncIn1+TruncIn2 : 0. SETTLE=2.
- Single request: Req0, In1=32'hAA14498B, In2=32'h0000001F.
  - Gnt0 pulses 1 cycle.
  - TruncEnable high exactly 2 cycles with those operands.
  - RspValid rises 2 edges after the sampling edge, with RspId=0, RspData=32'hAA1449AA; OpCount=1.
- Contention: Req0 (5,7) and Req1 (10,20) asserted together from reset.
  - Requester 0 is served first (RspData=12, RspId=0), then requester 1 (RspData=30, RspId=1).
  - Gnt0/Gnt1 never overlap.
- Round-robin fairness: both requests held continuously for 6 operations.
  - RspId sequence is 0,1,0,1,0,1; OpCount=6.
- Backpressure: RspReady=0 for 10 cycles after RspValid.
  - RspValid/RspData/RspId stay stable; Busy=1; no new Gnt while Req1 is pending.
  - RspReady=1 -> RspValid drops next edge, then Gnt1 follows.
- Reset mid-operation: assert Rst_n=0 during the second RUN cycle.
  - All outputs go to 0 immediately, with no RspValid.
  - After release, the same request is served normally and OpCount restarts from 1.
- Parameter and wrap: SETTLE=1 gives TruncEnable high exactly 1 cycle.
  - CNT_W=2 with 5 operations gives OpCount=1.
